// File: rtl/hc595_chain_driver_pkg.sv
// hc595_pkg: shared FSM state type and frame-width helper for the 595 chain driver
package hc595_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  function automatic int frame_bits(input int n_chips);
    return 8 * n_chips;
  endfunction
endpackage

// File: rtl/hc595_chain_driver_if.sv
// hc595_chain_driver_if: frame handshake plus 595 pin bundle between display logic and the driver
interface hc595_chain_driver_if #(parameter int W = 16);
  logic [W-1:0] i_data;
  logic i_start;
  logic i_auto;
  logic o_busy;
  logic o_done;
  logic o_dio;
  logic o_srclk;
  logic o_rclk;
  modport master (output i_data, i_start, i_auto, input o_busy, o_done, o_dio, o_srclk, o_rclk);
  modport slave (input i_data, i_start, i_auto, output o_busy, o_done, o_dio, o_srclk, o_rclk);
endinterface

// File: rtl/hc595_chain_driver_tick_gen.sv
// hc595_tick_gen: one-cycle tick every HALF_DIV clocks while enabled, cleared when disabled
module hc595_tick_gen #(parameter int HALF_DIV = 2) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
  logic [CW-1:0] r_cnt;
  logic w_wrap;
  assign w_wrap = r_cnt == CW'(HALF_DIV - 1);
  assign o_tick = i_en & w_wrap;
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) r_cnt <= '0;
    else r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
  end
endmodule

// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver: serialises a word into a chain of 74HC595s and pulses the storage latch
module hc595_chain_driver import hc595_pkg::*; #(
  parameter int N_CHIPS   = 2,
  parameter int HALF_DIV  = 2,
  parameter int LSB_FIRST = 0
) (
  input logic i_clk,
  input logic i_rst,
  hc595_chain_driver_if.slave bus
);
  localparam int W = frame_bits(N_CHIPS);
  localparam int BW = $clog2(W + 1);
  localparam bit LSB = LSB_FIRST != 0;
  generate
    if (N_CHIPS < 1 || HALF_DIV < 1) begin : g_bad_params
      $error("hc595_chain_driver: N_CHIPS and HALF_DIV must be >= 1");
    end
  endgenerate
  state_t r_state, w_state_n;
  logic [BW-1:0] r_bit, w_bit_n;
  logic [W-1:0] r_sh, w_sh_n;
  logic r_dio, r_srclk, r_rclk, r_busy, r_done;
  logic w_dio_n, w_srclk_n, w_rclk_n, w_busy_n, w_done_n;
  logic w_tick, w_tick_en;
  assign w_tick_en = r_state != IDLE;
  hc595_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_tick_en),
    .o_tick(w_tick)
  );
  // the shadow register is pre-shifted so its outgoing end always holds the next bit to send
  always_comb begin
    w_state_n = r_state;
    w_bit_n   = r_bit;
    w_sh_n    = r_sh;
    w_dio_n   = r_dio;
    w_srclk_n = r_srclk;
    w_rclk_n  = r_rclk;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: if (bus.i_start || bus.i_auto) begin
        w_state_n = SHIFT;
        w_bit_n   = '0;
        w_sh_n    = LSB ? bus.i_data >> 1 : bus.i_data << 1;
        w_dio_n   = LSB ? bus.i_data[0] : bus.i_data[W-1];
        w_srclk_n = 1'b0;
        w_busy_n  = 1'b1;
      end
      SHIFT: if (w_tick) begin
        if (!r_srclk) w_srclk_n = 1'b1;
        else if (r_bit == BW'(W - 1)) begin
          w_state_n = LATCH;
          w_srclk_n = 1'b0;
          w_rclk_n  = 1'b1;
        end else begin
          w_bit_n   = r_bit + BW'(1);
          w_srclk_n = 1'b0;
          w_dio_n   = LSB ? r_sh[0] : r_sh[W-1];
          w_sh_n    = LSB ? r_sh >> 1 : r_sh << 1;
        end
      end
      LATCH: if (w_tick) begin
        w_state_n = IDLE;
        w_rclk_n  = 1'b0;
        w_busy_n  = 1'b0;
        w_done_n  = 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_sh    <= '0;
      r_dio   <= 1'b0;
      r_srclk <= 1'b0;
      r_rclk  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_bit   <= w_bit_n;
      r_sh    <= w_sh_n;
      r_dio   <= w_dio_n;
      r_srclk <= w_srclk_n;
      r_rclk  <= w_rclk_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end
  assign bus.o_dio   = r_dio;
  assign bus.o_srclk = r_srclk;
  assign bus.o_rclk  = r_rclk;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
endmodule

// File: tb/tb_hc595_chain_driver.sv
// tb_hc595_chain_driver: directed frames against a bit scoreboard popped at every SRCLK rising edge
module tb_hc595_chain_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  logic q0[$];
  logic q1[$];
  int edges0 = 0, edges1 = 0, rclk0 = 0;
  logic p_sr0 = 1'b0, p_dio0 = 1'b0, p_rc0 = 1'b0;
  logic p_sr1 = 1'b0, p_dio1 = 1'b0, p_rc1 = 1'b0;
  always #5 clk = ~clk;
  hc595_chain_driver_if #(.W(16)) b0();
  hc595_chain_driver_if #(.W(24)) b1();
  hc595_chain_driver #(.N_CHIPS(2), .HALF_DIV(2), .LSB_FIRST(0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(b0));
  hc595_chain_driver #(.N_CHIPS(3), .HALF_DIV(1), .LSB_FIRST(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push0(input logic [15:0] d);
    for (int i = 15; i >= 0; i--) q0.push_back(d[i]);
  endtask
  task automatic push1(input logic [23:0] d);
    for (int i = 0; i < 24; i++) q1.push_back(d[i]);
  endtask
  always @(negedge clk) begin
    if (b0.o_srclk && !p_sr0) begin
      if (q0.size() == 0) chk("edge0_unexpected", 1, 0);
      else chk("dio0", b0.o_dio, q0.pop_front());
      chk("dio0_setup", b0.o_dio, p_dio0);
      edges0++;
    end
    if (b0.o_rclk && !p_rc0) chk("latch0_bits_left", q0.size(), 0);
    if (b0.o_rclk) rclk0++;
    p_sr0 = b0.o_srclk;
    p_dio0 = b0.o_dio;
    p_rc0 = b0.o_rclk;
  end
  always @(negedge clk) begin
    if (b1.o_srclk && !p_sr1) begin
      if (q1.size() == 0) chk("edge1_unexpected", 1, 0);
      else chk("dio1", b1.o_dio, q1.pop_front());
      chk("dio1_setup", b1.o_dio, p_dio1);
      edges1++;
    end
    if (b1.o_rclk && !p_rc1) chk("latch1_bits_left", q1.size(), 0);
    p_sr1 = b1.o_srclk;
    p_dio1 = b1.o_dio;
    p_rc1 = b1.o_rclk;
  end
  // cycle n is the n-th negedge after the capture edge; returns at the negedge where Done is seen
  task automatic measure(input int s, input int poke, output int done_at, output int rc_first,
                         output int rc_last, output int bz_first, output int bz_last);
    logic bz, rc, dn;
    done_at = -1; rc_first = -1; rc_last = -1; bz_first = -1; bz_last = -1;
    for (int n = 1; n <= 200 && done_at < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        b0.i_start = 1'b0;
        b1.i_start = 1'b0;
      end
      if (poke > 0 && n == poke) begin
        b0.i_start = 1'b1;
        b0.i_data = ~b0.i_data;
      end
      if (poke > 0 && n == poke + 1) b0.i_start = 1'b0;
      bz = s ? b1.o_busy : b0.o_busy;
      rc = s ? b1.o_rclk : b0.o_rclk;
      dn = s ? b1.o_done : b0.o_done;
      if (rc) begin
        if (rc_first < 0) rc_first = n;
        rc_last = n;
      end
      if (bz) begin
        if (bz_first < 0) bz_first = n;
        bz_last = n;
      end
      if (dn) done_at = n;
    end
  endtask
  task automatic run0(input string tag, input logic [15:0] d, input int poke, input bit use_auto);
    int e, da, rf, rl, bf, bl;
    b0.i_data = d;
    if (use_auto) b0.i_auto = 1'b1;
    else b0.i_start = 1'b1;
    push0(d);
    e = edges0;
    measure(0, poke, da, rf, rl, bf, bl);
    chk({tag, "_done_at"}, da, 67);
    chk({tag, "_rclk_first"}, rf, 65);
    chk({tag, "_rclk_last"}, rl, 66);
    chk({tag, "_busy_first"}, bf, 1);
    chk({tag, "_busy_last"}, bl, 66);
    chk({tag, "_edges"}, edges0 - e, 16);
    chk({tag, "_bits_left"}, q0.size(), 0);
  endtask
  initial begin
    int e, da, rf, rl, bf, bl, r, extra_done, extra_busy;
    b0.i_start = 1'b0; b0.i_auto = 1'b0; b0.i_data = '0;
    b1.i_start = 1'b0; b1.i_auto = 1'b0; b1.i_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_out0", {b0.o_dio, b0.o_srclk, b0.o_rclk, b0.o_busy, b0.o_done}, 0);
    chk("reset_out1", {b1.o_dio, b1.o_srclk, b1.o_rclk, b1.o_busy, b1.o_done}, 0);
    rst = 1'b0;
    @(negedge clk);
    run0("a5c3", 16'hA5C3, 0, 1'b0);
    run0("restart", 16'h5A0F, 10, 1'b0);
    extra_done = 0; extra_busy = 0;
    repeat (80) begin
      @(negedge clk);
      if (b0.o_done) extra_done++;
      if (b0.o_busy) extra_busy++;
    end
    chk("restart_extra_done", extra_done, 0);
    chk("restart_extra_busy", extra_busy, 0);
    b0.i_data = 16'h3C96;
    b0.i_start = 1'b1;
    push0(16'h3C96);
    r = rclk0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) b0.i_start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", {b0.o_dio, b0.o_srclk, b0.o_rclk, b0.o_busy, b0.o_done}, 0);
    rst = 1'b0;
    q0.delete();
    chk("midrst_no_latch", rclk0 - r, 0);
    @(negedge clk);
    run0("after_rst", 16'h1234, 0, 1'b0);
    @(negedge clk);
    run0("auto1", 16'h8001, 0, 1'b1);
    run0("auto2", 16'h7FFE, 0, 1'b1);
    run0("auto3", 16'hC3A5, 0, 1'b1);
    b0.i_auto = 1'b0;
    repeat (5) @(negedge clk);
    chk("auto_off_idle", b0.o_busy, 0);
    b1.i_data = 24'h000001;
    b1.i_start = 1'b1;
    push1(24'h000001);
    e = edges1;
    measure(1, 0, da, rf, rl, bf, bl);
    chk("lsb_done_at", da, 50);
    chk("lsb_rclk_first", rf, 49);
    chk("lsb_rclk_last", rl, 49);
    chk("lsb_busy_first", bf, 1);
    chk("lsb_busy_last", bl, 49);
    chk("lsb_edges", edges1 - e, 24);
    chk("lsb_bits_left", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/hc595_chain_driver.md
Name: hc595_chain_driver

Overview:
- Serialises a parallel word into a daisy chain of N_CHIPS 74HC595 shift registers, then pulses the storage latch.
- All outputs are generated from the single system clock using a clock-enable divider. No derived clocks are used.
- A Start/Busy/Done handshake triggers single frames. An Auto mode refreshes continuously.
- Sits between display/LED logic (segment, select and LED words) and the board's 595 pins.

Parameters:
- N_CHIPS, 2, number of cascaded 595s; W = 8*N_CHIPS bits per frame.
- HALF_DIV, 2, system clocks per SRCLK half-period (>=1). 50 MHz with HALF_DIV=2 gives 12.5 MHz SRCLK.
- LSB_FIRST, 0, 0 = Data[W-1] shifted first; 1 = Data[0] shifted first.

Ports:
- Clk, input, 1, system clock.
- Reset, input, 1, synchronous active-high reset.
- Data, input, W, frame word; sampled only at frame capture.
- Start, input, 1, request one frame; sampled in IDLE only.
- Auto, input, 1, when 1, start a new frame automatically after every Done.
- Busy, output, 1, high from the cycle after capture through the last LATCH cycle.
- Done, output, 1, one-cycle pulse at frame completion.
- DIO, output, 1, serial data to the first chip's SER pin.
- SRCLK, output, 1, shift clock; the 595 samples DIO on the rising edge.
- RCLK, output, 1, storage latch clock.

Behaviour:
- Interface: one clock (Clk); synchronous, active-high reset (Reset). All outputs are registered.
- Reset: on the next Clk edge with Reset=1, DIO=0, SRCLK=0, RCLK=0, Busy=0, Done=0, FSM=IDLE, and all counters clear. Reset overrides every other input.
- FSM states: IDLE, SHIFT, LATCH. H = HALF_DIV.
- IDLE -> SHIFT:
  - Trigger: at an edge t0 where (Start | Auto) = 1.
  - Data is copied to the shadow register and the bit counter is set to 0.
  - At t0+1: Busy=1, SRCLK=0, DIO = first bit.
- SHIFT, bit k (k = 0..W-1):
  - SRCLK low for cycles [t0+1+2kH, t0+1+(2k+1)H).
  - SRCLK high for the following H cycles.
  - DIO changes only in the cycle SRCLK goes low, so setup and hold at the rising edge are each >= H clocks.
- SHIFT -> LATCH: after the high phase of bit W-1. From t0+1+2WH:
  - SRCLK=0 and RCLK=1 for H cycles.
  - DIO holds the last bit.
- LATCH -> IDLE:
  - At t0+1+(2W+1)H: RCLK=0, Busy=0, Done=1 for exactly one cycle.
  - Frame length is (2W+1)H+1 cycles from capture to Done. The default is 67.
- Auto=1 while in IDLE: Done and the next capture occur in the same cycle, so the next frame begins at Done+1 with no idle gap.
- Start while Busy: ignored, not queued.
- Data changes mid-frame: no effect, because the shadow register is used.
- Reset mid-frame: RCLK is never pulsed, so the 595 outputs keep the previous latched frame. Shift-register contents are don't-care.
- Bit order:
  - LSB_FIRST=0 sends Data[W-1] ... Data[0].
  - LSB_FIRST=1 sends Data[0] ... Data[W-1].
  - The last bit shifted lands in QH... wait, precisely: the last bit shifted lands in the first chip's QA; the first bit shifted lands in the far chip's QH.
- Counter widths:
  - Half-period counter: $clog2(H) bits, minimum 1. It wraps at H-1.
  - Bit counter: $clog2(W+1) bits. No counter overflows for any legal parameter.
- Elaboration check: N_CHIPS >= 1 and HALF_DIV >= 1, otherwise $error.

Decomposition:
- Package hc595_pkg:
  - state enum typedef {IDLE, SHIFT, LATCH}.
  - localparam function for W.
- Sub-module hc595_tick_gen:
  - Counts HALF_DIV.
  - Emits a one-cycle `tick` at each half-period boundary while enabled.
  - Clears on Reset or when disabled.
- The FSM and shift register live in the top module.

Test Plan:
- Defaults; Data=16'hA5C3, one Start pulse -> 16 SRCLK rising edges; DIO sampled at the rising edges = A5C3 MSB-first; RCLK high cycles 65-66 after capture; Done at cycle 67; Busy high cycles 1-66.
- LSB_FIRST=1, N_CHIPS=3, Data=24'h000001 -> the first sampled bit is 1 and the remaining 23 are 0; exactly 24 rising edges before RCLK.
- HALF_DIV=1 -> SRCLK toggles every cycle; Done at capture+2*16+2 = 34; DIO is stable across every rising edge.
- Start re-asserted at cycle 10 of a frame, and Data changed at cycle 10 -> no restart; the shifted bits equal the captured word; exactly one Done.
- Reset asserted at cycle 30 -> next cycle all outputs are 0; RCLK is never high; the next Start produces a full, correct frame.
- Auto=1 held for 3 frames -> Done every 67 cycles; each frame starts the cycle after Done; a Data update between frames appears in the next frame.
